instr_prefetch: RTL and testbench

//  Instruction-side front end of proc: drives the instruction memory handshake
//  (instr_req/instr_addr/instr_valid/instr_read) and buffers fetched words in a small FIFO.

---
 rtl/instr_prefetch_if.sv | 21 ++
 rtl/instr_prefetch.sv | 80 ++++++++
 tb/tb_instr_prefetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: instruction-memory fetch handshake plus the decode-side valid/ready port.
interface instr_prefetch_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_read;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [31:0] flush_pc;
  modport master (
    output instr_req, instr_addr, out_valid, out_instr, out_pc,
    input  instr_valid, instr_read, out_ready, flush, flush_pc
  );
  modport slave (
    input  instr_req, instr_addr, out_valid, out_instr, out_pc,
    output instr_valid, instr_read, out_ready, flush, flush_pc
  );
endinterface

// File: rtl/instr_prefetch.sv
// instr_prefetch: one-outstanding fetch FSM feeding a DEPTH-entry {instr, pc} FIFO to decode.
// Define PREFETCH_BSWAP_EN to byte-swap fetched words before they are buffered.
`ifndef PC_INIT_ADDR
`define PC_INIT_ADDR 32'h0000_1000
`endif
module instr_prefetch #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = `PC_INIT_ADDR
) (
  input logic              i_clk,
  input logic              i_res,
  instr_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_fetch_pc, r_last_instr, r_last_pc, w_word, w_head_instr, w_head_pc;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_push, w_pop, w_full, w_valid;
`ifdef PREFETCH_BSWAP_EN
  assign w_word = {bus.instr_read[7:0], bus.instr_read[15:8], bus.instr_read[23:16], bus.instr_read[31:24]};
`else
  assign w_word = bus.instr_read;
`endif
  assign w_full       = r_count == (AW+1)'(DEPTH);
  assign w_valid      = r_count != '0;
  assign w_push       = r_state == REQ && bus.instr_valid && !bus.flush;
  assign w_pop        = w_valid && bus.out_ready && !bus.flush;
  assign w_head_instr = w_valid ? r_mem_instr[r_rp] : r_last_instr;
  assign w_head_pc    = w_valid ? r_mem_pc[r_rp] : r_last_pc;
  assign bus.instr_req  = r_state == REQ;
  assign bus.instr_addr = r_fetch_pc;
  assign bus.out_valid  = w_valid;
  assign bus.out_instr  = w_head_instr;
  assign bus.out_pc     = w_head_pc;
  always_comb begin
    w_next = r_state;
    w_next = bus.flush ? GAP :
             r_state == IDLE ? (w_full ? IDLE : REQ) :
             r_state == REQ ? (bus.instr_valid ? GAP : REQ) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_state      <= IDLE;
      r_fetch_pc   <= PC_INIT;
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else begin
      r_state <= w_next;
      // Shadow of the head so an empty FIFO keeps presenting the last word seen.
      if (w_valid) begin
        r_last_instr <= w_head_instr;
        r_last_pc    <= w_head_pc;
      end
      if (bus.flush) begin
        r_fetch_pc <= {bus.flush_pc[31:2], 2'b00};
        r_wp       <= '0;
        r_rp       <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_instr[r_wp] <= w_word;
      r_mem_pc[r_wp]    <= r_fetch_pc;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: latency-configurable memory model with a scoreboard of expected {instr, pc}.
module tb_instr_prefetch;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  logic [63:0] sb[$];
  logic [63:0] sb_e;
  logic [31:0] exp_pc = 32'h1000;
  logic        prev_req = 1'b0;

  instr_prefetch_if bus();
  instr_prefetch #(.DEPTH(4), .PC_INIT(32'h1000)) dut (.i_clk(clk), .i_res(res), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h1000 ? 32'h00500093 : a == 32'h3000 ? 32'h93005000 : {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef PREFETCH_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    bus.instr_valid = 1'b0;
    bus.instr_read  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.instr_req) begin
        cnt = 0;
        bus.instr_valid = 1'b0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          bus.instr_valid = 1'b1;
          bus.instr_read  = mem_word(bus.instr_addr);
        end
      end
    end
  end

  // Decides what the coming posedge will do, from inputs that are already stable.
  initial forever begin
    @(negedge clk);
    #2;
    if (!res) begin
      sb.delete();
      exp_pc = 32'h1000;
    end else if (bus.flush) begin
      sb.delete();
      exp_pc = {bus.flush_pc[31:2], 2'b00};
    end else begin
      if (bus.instr_req && !prev_req) begin
        checks++;
        if (bus.instr_addr !== exp_pc) begin
          errors++;
          $display("FAIL req_addr got %h exp %h", bus.instr_addr, exp_pc);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_pop got instr %h pc %h exp nothing", bus.out_instr, bus.out_pc);
        end else begin
          sb_e = sb.pop_front();
          if ({bus.out_instr, bus.out_pc} !== sb_e) begin
            errors++;
            $display("FAIL sb_pop got %h/%h exp %h/%h", bus.out_instr, bus.out_pc, sb_e[63:32], sb_e[31:0]);
          end
        end
      end
      if (bus.instr_req && bus.instr_valid) begin
        sb.push_back({stored(mem_word(exp_pc)), exp_pc});
        exp_pc += 32'd4;
      end
    end
    prev_req = bus.instr_req;
  end

  // sel: 0 wait instr_req=1, 1 wait out_valid=1, 2 wait instr_req=0; cyc=n on timeout
  task automatic wait_sig(input int sel, input int n, output int cyc);
    for (cyc = 0; cyc < n; cyc++) begin
      if ((sel == 0 && bus.instr_req) || (sel == 1 && bus.out_valid) || (sel == 2 && !bus.instr_req)) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic test_reset();
    int cyc;
    mem_lat = 50;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    res = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.instr_req); end
    checks++; if (bus.instr_addr !== 32'h1000) begin errors++; $display("FAIL rst_addr got %h exp 00001000", bus.instr_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.out_pc); end
    res = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", bus.instr_req); end
    wait_sig(1, 80, cyc);
    checks++; if (cyc != 50) begin errors++; $display("FAIL first_latency got %0d exp 50", cyc); end
    checks++; if (bus.out_instr !== stored(32'h00500093)) begin errors++; $display("FAIL first_instr got %h exp %h", bus.out_instr, stored(32'h00500093)); end
    checks++; if (bus.out_pc !== 32'h1000) begin errors++; $display("FAIL first_pc got %h exp 00001000", bus.out_pc); end
  endtask

  task automatic test_fill();
    int cyc;
    mem_lat = 2;
    repeat (40) @(negedge clk);
    checks++; if (sb.size() != 4) begin errors++; $display("FAIL fill_count got %0d exp 4", sb.size()); end
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", bus.instr_req); end
    checks++; if (bus.out_pc !== 32'h1000) begin errors++; $display("FAIL full_head got %h exp 00001000", bus.out_pc); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    wait_sig(0, 10, cyc);
    checks++; if (cyc == 10 || bus.instr_addr !== 32'h1010) begin errors++; $display("FAIL refill_addr got %h exp 00001010", bus.instr_addr); end
    bus.out_ready = 1'b1;
    repeat (30) @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush_inflight();
    int cyc;
    mem_lat = 20;
    bus.out_ready = 1'b1;
    do_reset();
    for (cyc = 0; cyc < 200; cyc++) begin
      if (bus.instr_req && bus.instr_addr == 32'h1008) break;
      @(negedge clk);
    end
    checks++; if (cyc == 200) begin errors++; $display("FAIL wait_1008 got timeout exp request"); end
    bus.flush = 1'b1;
    bus.flush_pc = 32'h2003;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL flush_req0 got %b exp 0", bus.instr_req); end
    @(negedge clk);
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL flush_req1 got %b exp 0", bus.instr_req); end
    @(negedge clk);
    checks++; if (bus.instr_req !== 1'b1 || bus.instr_addr !== 32'h2000) begin errors++; $display("FAIL flush_redirect got %b/%h exp 1/00002000", bus.instr_req, bus.instr_addr); end
    wait_sig(1, 40, cyc);
    checks++; if (cyc == 40 || bus.out_pc !== 32'h2000) begin errors++; $display("FAIL flush_pc got %h exp 00002000", bus.out_pc); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_flush_collide();
    int cyc;
    mem_lat = 3;
    bus.out_ready = 1'b0;
    do_reset();
    for (cyc = 0; cyc < 100; cyc++) begin
      if (sb.size() == 3 && bus.instr_req && bus.instr_valid) break;
      @(negedge clk);
    end
    checks++; if (cyc == 100) begin errors++; $display("FAIL wait_collide got timeout exp 3 entries"); end
    bus.flush = 1'b1;
    bus.flush_pc = 32'h4000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL collide_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h1000) begin errors++; $display("FAIL collide_hold got %h exp 00001000", bus.out_pc); end
    wait_sig(0, 5, cyc);
    checks++; if (cyc == 5 || bus.instr_addr !== 32'h4000) begin errors++; $display("FAIL collide_addr got %h exp 00004000", bus.instr_addr); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    mem_lat = 4;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h5000;
    @(negedge clk);
    bus.flush_pc = 32'h6006;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_sig(0, 5, cyc);
    checks++; if (cyc == 5 || bus.instr_addr !== 32'h6004) begin errors++; $display("FAIL b2b_addr got %h exp 00006004", bus.instr_addr); end
    wait_sig(1, 20, cyc);
    checks++; if (cyc == 20 || bus.out_pc !== 32'h6004) begin errors++; $display("FAIL b2b_pc got %h exp 00006004", bus.out_pc); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc;
    mem_lat = 1;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_sig(0, 5, cyc);
    checks++; if (cyc == 5 || bus.instr_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", bus.instr_addr); end
    wait_sig(2, 5, cyc);
    wait_sig(0, 5, cyc);
    checks++; if (cyc == 5 || bus.instr_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", bus.instr_addr); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bswap_reset();
    int cyc;
    mem_lat = 2;
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h3000;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_sig(1, 20, cyc);
`ifdef PREFETCH_BSWAP_EN
    checks++; if (cyc == 20 || bus.out_instr !== 32'h00500093) begin errors++; $display("FAIL bswap got %h exp 00500093", bus.out_instr); end
`else
    checks++; if (cyc == 20 || bus.out_instr !== 32'h93005000) begin errors++; $display("FAIL noswap got %h exp 93005000", bus.out_instr); end
`endif
    mem_lat = 4;
    wait_sig(0, 10, cyc);
    checks++; if (cyc == 10 || bus.instr_addr !== 32'h3004) begin errors++; $display("FAIL midreq_addr got %h exp 00003004", bus.instr_addr); end
    res = 1'b0;
    @(negedge clk);
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL midrst_req got %b exp 0", bus.instr_req); end
    checks++; if (bus.instr_addr !== 32'h1000) begin errors++; $display("FAIL midrst_addr got %h exp 00001000", bus.instr_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin errors++; $display("FAIL midrst_head got %h/%h exp 0/0", bus.out_instr, bus.out_pc); end
    res = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    test_reset();
    test_fill();
    test_flush_inflight();
    test_flush_collide();
    test_back_to_back();
    test_wrap();
    test_bswap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
